// File: rtl/sat_pkg.sv
// Shared types and constants for the DPLL solver implication path
// (variable ids, queued implications and the writeback FSM states).
package sat_pkg;

  localparam int NUM_VARIABLE   = 128;
  localparam int VARIABLE_INDEX = $clog2(NUM_VARIABLE) - 1;
  localparam int QUEUE_DEPTH    = 8;
  localparam int LEVEL_WIDTH    = 8;

  typedef logic [VARIABLE_INDEX:0] var_id_t;

  typedef struct packed {
    var_id_t variable;
    logic    val;
  } implication_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    CHECK,
    CONFLICT
  } wb_state_e;

endpackage

// File: rtl/impl_fifo.sv
// Synchronous FIFO of implications. The pointers carry one extra wrap bit,
// so full and empty can be told apart without a separate occupancy counter.
module impl_fifo
  import sat_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  implication_t push_data,
  output implication_t head,
  output logic         full,
  output logic         empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  implication_t     mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; an entry is only ever read after it was written.
  always_ff @(posedge clock) begin
    if (reset_n && !flush && do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/implication_writeback.sv
// Drains queued unit-clause implications into the variable state table and trail,
// dropping duplicates and flagging conflicts. IMPL_STATS_EN adds write/dup counters.
module implication_writeback
  import sat_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    imp_valid,
  input  logic [VARIABLE_INDEX:0] imp_variable,
  input  logic                    imp_val,
  output logic                    imp_ready,
  input  logic [LEVEL_WIDTH-1:0]  cur_level,
  input  logic                    flush,
  output logic [VARIABLE_INDEX:0] vst_rd_addr,
  input  logic                    vst_rd_unassign,
  input  logic                    vst_rd_val,
  output logic                    vst_wr_en,
  output logic [VARIABLE_INDEX:0] vst_wr_addr,
  output logic                    vst_wr_val,
  output logic [LEVEL_WIDTH-1:0]  vst_wr_level,
  output logic                    trail_push,
  output logic [VARIABLE_INDEX:0] trail_variable,
  output logic                    conflict,
  output logic [VARIABLE_INDEX:0] conflict_variable,
  output logic                    idle,
  output logic [15:0]             stat_written,
  output logic [15:0]             stat_dup
);

  wb_state_e    state;
  wb_state_e    next_state;
  implication_t head;
  implication_t push_data;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic         write_now;
  logic         conflict_set;

  assign imp_ready = !fifo_full && (state != CONFLICT) && !flush;
  assign push      = imp_valid && imp_ready;
  assign push_data = '{variable: imp_variable, val: imp_val};
  assign idle      = fifo_empty && (state == IDLE);

  impl_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = state;
    pop          = 1'b0;
    write_now    = 1'b0;
    conflict_set = 1'b0;
    vst_rd_addr  = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          vst_rd_addr = head.variable;
          next_state  = LOOKUP;
        end
      end
      LOOKUP: begin
        vst_rd_addr = head.variable;
        next_state  = CHECK;
      end
      CHECK: begin
        vst_rd_addr = head.variable;
        if (vst_rd_unassign) begin
          write_now  = 1'b1;
          pop        = 1'b1;
          next_state = IDLE;
        end else if (vst_rd_val == head.val) begin
          pop        = 1'b1;
          next_state = IDLE;
        end else begin
          conflict_set = 1'b1;
          next_state   = CONFLICT;
        end
      end
      CONFLICT: next_state = CONFLICT;
      default:  next_state = IDLE;
    endcase
    // A write racing a backtrack or reset must never reach the table.
    if (flush || !reset_n) begin
      next_state   = IDLE;
      pop          = 1'b0;
      write_now    = 1'b0;
      conflict_set = 1'b0;
    end
  end

  assign vst_wr_en      = write_now;
  assign vst_wr_addr    = write_now ? head.variable : '0;
  assign vst_wr_val     = write_now && head.val;
  assign vst_wr_level   = write_now ? cur_level : '0;
  assign trail_push     = write_now;
  assign trail_variable = write_now ? head.variable : '0;

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      conflict          <= 1'b0;
      conflict_variable <= '0;
    end else if (conflict_set) begin
      conflict          <= 1'b1;
      conflict_variable <= head.variable;
    end
  end

`ifdef IMPL_STATS_EN
  logic        dup_drop;
  logic [15:0] written_count;
  logic [15:0] dup_count;

  assign dup_drop = pop && !write_now;

  // Counters survive a backtrack; only reset clears them.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      written_count <= '0;
      dup_count     <= '0;
    end else begin
      if (write_now && written_count != 16'hFFFF) written_count <= written_count + 16'd1;
      if (dup_drop && dup_count != 16'hFFFF)      dup_count     <= dup_count + 16'd1;
    end
  end

  assign stat_written = written_count;
  assign stat_dup     = dup_count;
`else
  assign stat_written = '0;
  assign stat_dup     = '0;
`endif

endmodule

// File: tb/tb_implication_writeback.sv
// Self-checking bench for implication_writeback: a behavioural state table with
// 1-cycle read latency, and a scoreboard of expected writes checked at each strobe.
module tb_implication_writeback;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       imp_valid = 1'b0;
  logic [6:0] imp_variable = '0;
  logic       imp_val = 1'b0;
  logic       imp_ready;
  logic [7:0] cur_level = '0;
  logic       flush = 1'b0;
  logic [6:0] vst_rd_addr;
  logic       vst_rd_unassign = 1'b1;
  logic       vst_rd_val = 1'b0;
  logic       vst_wr_en;
  logic [6:0] vst_wr_addr;
  logic       vst_wr_val;
  logic [7:0] vst_wr_level;
  logic       trail_push;
  logic [6:0] trail_variable;
  logic       conflict;
  logic [6:0] conflict_variable;
  logic       idle;
  logic [15:0] stat_written;
  logic [15:0] stat_dup;

  typedef struct {
    logic [6:0] vid;
    logic       val;
    logic [7:0] lvl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   writes_seen = 0;
  bit   tbl_u [128];
  bit   tbl_v [128];
  bit   rd_next_u = 1'b1;
  bit   rd_next_v = 1'b0;

  implication_writeback dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .imp_valid         (imp_valid),
    .imp_variable      (imp_variable),
    .imp_val           (imp_val),
    .imp_ready         (imp_ready),
    .cur_level         (cur_level),
    .flush             (flush),
    .vst_rd_addr       (vst_rd_addr),
    .vst_rd_unassign   (vst_rd_unassign),
    .vst_rd_val        (vst_rd_val),
    .vst_wr_en         (vst_wr_en),
    .vst_wr_addr       (vst_wr_addr),
    .vst_wr_val        (vst_wr_val),
    .vst_wr_level      (vst_wr_level),
    .trail_push        (trail_push),
    .trail_variable    (trail_variable),
    .conflict          (conflict),
    .conflict_variable (conflict_variable),
    .idle              (idle),
    .stat_written      (stat_written),
    .stat_dup          (stat_dup)
  );

  always #5 clock = ~clock;

  // Scoreboard check and table update happen mid-cycle where DUT outputs are stable.
  always @(negedge clock) begin
    if (vst_wr_en) begin
      writes_seen++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write: got addr=%0d val=%0d want no write", vst_wr_addr, vst_wr_val);
      end else begin
        mon_e = sb.pop_front();
        if (vst_wr_addr !== mon_e.vid || vst_wr_val !== mon_e.val || vst_wr_level !== mon_e.lvl ||
            trail_push !== 1'b1 || trail_variable !== mon_e.vid) begin
          bad++;
          $display("[TB] FAIL write_entry: got addr=%0d val=%0d lvl=%0d trail=%0d/%0d want addr=%0d val=%0d lvl=%0d trail=1/%0d",
                   vst_wr_addr, vst_wr_val, vst_wr_level, trail_push, trail_variable,
                   mon_e.vid, mon_e.val, mon_e.lvl, mon_e.vid);
        end
      end
      tbl_u[vst_wr_addr] = 1'b0;
      tbl_v[vst_wr_addr] = vst_wr_val;
    end else if (trail_push) begin
      total++;
      bad++;
      $display("[TB] FAIL trail_without_write: got trail_push=1 want 0");
    end
    rd_next_u = tbl_u[vst_rd_addr];
    rd_next_v = tbl_v[vst_rd_addr];
  end

  always @(posedge clock) begin
    vst_rd_unassign <= rd_next_u;
    vst_rd_val      <= rd_next_v;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    total++;
    if (idle !== 1'b1 || imp_ready !== 1'b1 || conflict !== 1'b0 || vst_wr_en !== 1'b0 || trail_push !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got idle=%0d ready=%0d conf=%0d wr=%0d trail=%0d want 1 1 0 0 0",
               idle, imp_ready, conflict, vst_wr_en, trail_push);
    end
    total++;
    if (vst_rd_addr !== 7'd0 || vst_wr_addr !== 7'd0 || vst_wr_level !== 8'd0 || trail_variable !== 7'd0 ||
        conflict_variable !== 7'd0 || stat_written !== 16'd0 || stat_dup !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_data: got rd=%0d wa=%0d wl=%0d tv=%0d cv=%0d sw=%0d sd=%0d want all 0",
               vst_rd_addr, vst_wr_addr, vst_wr_level, trail_variable, conflict_variable, stat_written, stat_dup);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    cur_level = 8'd3;
    imp_variable = 7'd5;
    imp_val = 1'b1;
    imp_valid = 1'b1;
    total++;
    if (imp_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_idle: got %0d want 1", imp_ready);
    end
    sb.push_back('{vid: 7'd5, val: 1'b1, lvl: 8'd3});
    tick();
    imp_valid = 1'b0;
    total++;
    if (vst_wr_en !== 1'b0 || idle !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_after_push: got wr=%0d idle=%0d want 0 0", vst_wr_en, idle);
    end
    tick();
    total++;
    if (vst_wr_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lookup_no_write: got %0d want 0", vst_wr_en);
    end
    tick();
    total++;
    if (vst_wr_en !== 1'b1 || vst_wr_level !== 8'd3) begin
      bad++;
      $display("[TB] FAIL write_latency: got wr=%0d lvl=%0d want 1 3", vst_wr_en, vst_wr_level);
    end
    tick();
    total++;
    if (idle !== 1'b1 || vst_wr_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_write: got idle=%0d wr=%0d want 1 0", idle, vst_wr_en);
    end
`ifdef IMPL_STATS_EN
    total++;
    if (stat_written !== 16'd1) begin
      bad++;
      $display("[TB] FAIL stat_written_one: got %0d want 1", stat_written);
    end
`endif
  endtask

  task automatic test_duplicate();
    int n;
    int base;
    base = writes_seen;
    tbl_u[9] = 1'b0;
    tbl_v[9] = 1'b0;
    imp_variable = 7'd9;
    imp_val = 1'b0;
    imp_valid = 1'b1;
    tick();
    imp_valid = 1'b0;
    n = 0;
    while (!idle && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (idle !== 1'b1 || conflict !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dup_drain: got idle=%0d conf=%0d want 1 0", idle, conflict);
    end
    total++;
    if (writes_seen != base) begin
      bad++;
      $display("[TB] FAIL dup_no_write: got %0d writes want 0", writes_seen - base);
    end
`ifdef IMPL_STATS_EN
    total++;
    if (stat_dup !== 16'd1) begin
      bad++;
      $display("[TB] FAIL stat_dup_one: got %0d want 1", stat_dup);
    end
`endif
  endtask

  task automatic test_conflict();
    int n;
    int errs;
    tbl_u[9] = 1'b0;
    tbl_v[9] = 1'b0;
    imp_variable = 7'd9;
    imp_val = 1'b1;
    imp_valid = 1'b1;
    tick();
    imp_valid = 1'b0;
    n = 0;
    while (!conflict && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (conflict !== 1'b1 || conflict_variable !== 7'd9) begin
      bad++;
      $display("[TB] FAIL conflict_raise: got conf=%0d var=%0d want 1 9", conflict, conflict_variable);
    end
    errs = 0;
    repeat (20) begin
      tick();
      if (conflict !== 1'b1 || imp_ready !== 1'b0 || idle !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("[TB] FAIL conflict_hold: got %0d bad cycles want 0", errs);
    end
    flush = 1'b1;
    #1;
    total++;
    if (imp_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ready_in_flush: got %0d want 0", imp_ready);
    end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (conflict !== 1'b0 || idle !== 1'b1 || imp_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush_recover: got conf=%0d idle=%0d ready=%0d want 0 1 1", conflict, idle, imp_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int base;
    int accepted;
    bit dropped;
    base = writes_seen;
    accepted = 0;
    dropped = 1'b0;
    cur_level = 8'd7;
    imp_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      imp_variable = 7'(20 + accepted);
      imp_val = accepted[0];
      if (!imp_ready) begin
        dropped = 1'b1;
        break;
      end
      sb.push_back('{vid: 7'(20 + accepted), val: accepted[0], lvl: 8'd7});
      accepted++;
      tick();
    end
    total++;
    if (!dropped || (accepted - (writes_seen - base)) != 8) begin
      bad++;
      $display("[TB] FAIL full_level: got dropped=%0d occupancy=%0d want 1 8", dropped, accepted - (writes_seen - base));
    end
    imp_variable = 7'd99;
    imp_val = 1'b1;
    tick();
    imp_valid = 1'b0;
    n = 0;
    while (!idle && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (writes_seen - base != accepted || idle !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drain_count: got %0d writes idle=%0d want %0d 1", writes_seen - base, idle, accepted);
    end
    total++;
    if (tbl_u[99] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL no_push_when_full: got var99 unassigned=%0d want 1", tbl_u[99]);
    end
  endtask

  task automatic test_write_then_conflict();
    int n;
    int base;
    base = writes_seen;
    cur_level = 8'd4;
    imp_variable = 7'd12;
    imp_val = 1'b1;
    imp_valid = 1'b1;
    sb.push_back('{vid: 7'd12, val: 1'b1, lvl: 8'd4});
    tick();
    imp_val = 1'b0;
    tick();
    imp_valid = 1'b0;
    n = 0;
    while (!conflict && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (conflict !== 1'b1 || conflict_variable !== 7'd12) begin
      bad++;
      $display("[TB] FAIL same_var_conflict: got conf=%0d var=%0d want 1 12", conflict, conflict_variable);
    end
    total++;
    if (writes_seen - base != 1 || sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL same_var_writes: got %0d writes pending=%0d want 1 0", writes_seen - base, sb.size());
    end
`ifdef IMPL_STATS_EN
    total++;
    if (stat_written !== 16'(writes_seen) || stat_dup !== 16'd1) begin
      bad++;
      $display("[TB] FAIL stat_totals: got w=%0d d=%0d want w=%0d d=1", stat_written, stat_dup, writes_seen);
    end
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_check();
    cur_level = 8'd5;
    imp_variable = 7'd40;
    imp_val = 1'b1;
    imp_valid = 1'b1;
    tick();
    imp_valid = 1'b0;
    tick();
    tick();
    total++;
    if (vst_wr_en !== 1'b1) begin
      bad++;
      $display("[TB] FAIL check_reached: got wr=%0d want 1", vst_wr_en);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (vst_wr_en !== 1'b0 || trail_push !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_kills_write: got wr=%0d trail=%0d want 0 0", vst_wr_en, trail_push);
    end
    tick();
    total++;
    if (idle !== 1'b1 || imp_ready !== 1'b1 || conflict !== 1'b0 || vst_rd_addr !== 7'd0 ||
        vst_wr_addr !== 7'd0 || trail_variable !== 7'd0 || stat_written !== 16'd0 || stat_dup !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_op: got idle=%0d ready=%0d conf=%0d rd=%0d wa=%0d tv=%0d sw=%0d sd=%0d want 1 1 0 0 0 0 0 0",
               idle, imp_ready, conflict, vst_rd_addr, vst_wr_addr, trail_variable, stat_written, stat_dup);
    end
    total++;
    if (tbl_u[40] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL var40_untouched: got unassigned=%0d want 1", tbl_u[40]);
    end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      tbl_u[i] = 1'b1;
      tbl_v[i] = 1'b0;
    end
    test_reset();
    test_single_write();
    test_duplicate();
    test_conflict();
    test_back_to_back();
    test_write_then_conflict();
    test_reset_mid_check();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_drained: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
